// File: rtl/iobuf_ctrl_pkg.sv
// Shared state encodings and direction constants for the bidirectional pad controller.
package iobuf_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_TURN_TX = 2'd1;
  localparam logic [1:0] ST_TX      = 2'd2;
  localparam logic [1:0] ST_TURN_RX = 2'd3;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

endpackage

// File: rtl/iobuf.sv
// Pad-level tristate buffer: t=1 releases a pin, t=0 drives i onto it; o always reflects the pin.
module iobuf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] o,
  inout  wire  [WIDTH-1:0] io
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_pin
    assign io[b] = t[b] ? 1'bz : i[b];
  end

  assign o = io;

endmodule

// File: rtl/iobuf_ctrl_filt.sv
// One receive bit: metastability synchronizer followed by a run-length deglitch filter.
module iobuf_ctrl_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic pad,
  output logic rx,
  output logic upd
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(FILTER_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   samp;
  logic                   last_samp;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   take;

  assign samp = sync[SYNC_STAGES-1];

  // cnt is the length of the current run of equal samples, including this one
  always_comb begin
    cnt_nxt = cnt;
    if (samp != last_samp) begin
      cnt_nxt = ONE;
    end else if (cnt != FULL) begin
      cnt_nxt = cnt + ONE;
    end
  end

  assign take = (cnt_nxt == FULL);
  assign upd  = take && (samp != rx);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync      <= '0;
      last_samp <= 1'b0;
      cnt       <= '0;
      rx        <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], pad};
      last_samp <= samp;
      cnt       <= cnt_nxt;
      if (take) begin
        rx <= samp;
      end
    end
  end

endmodule

// File: rtl/iobuf_ctrl.sv
// Bidirectional pad controller: handshaked direction changes with tristated dead time,
// registered transmit drive and a synchronized, deglitched receive path.
module iobuf_ctrl
  import iobuf_ctrl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             dir_req_valid,
  input  logic             dir_req_out,
  output logic             dir_req_ready,
  output logic [1:0]       dir_state,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_change,
  inout  wire  [WIDTH-1:0] io
);

  localparam int TCW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TCW-1:0] TURN_LOAD = TCW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam int VLIM = SYNC_STAGES + FILTER_LEN;
  localparam int VCW  = $clog2(VLIM + 1);
  localparam logic [VCW-1:0] VLAST = VCW'(VLIM - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TCW-1:0]   turn_cnt;
  logic [TCW-1:0]   turn_nxt;
  logic [VCW-1:0]   vcnt;
  logic [WIDTH-1:0] io_t;
  logic [WIDTH-1:0] io_i;
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] upd;
  logic             accept;

  assign dir_req_ready = resetn && ((state == ST_RX) || (state == ST_TX));
  assign accept        = dir_req_valid && dir_req_ready;
  assign dir_state     = state;

  always_comb begin
    state_nxt = state;
    turn_nxt  = turn_cnt;
    case (state)
      ST_RX: begin
        if (accept && (dir_req_out == DIR_TX)) begin
          if (TURN_CYCLES > 0) begin
            state_nxt = ST_TURN_TX;
            turn_nxt  = TURN_LOAD;
          end else begin
            state_nxt = ST_TX;
          end
        end
      end
      ST_TX: begin
        if (accept && (dir_req_out == DIR_RX)) begin
          if (TURN_CYCLES > 0) begin
            state_nxt = ST_TURN_RX;
            turn_nxt  = TURN_LOAD;
          end else begin
            state_nxt = ST_RX;
          end
        end
      end
      ST_TURN_TX: begin
        if (turn_cnt == '0) state_nxt = ST_TX;
        else                turn_nxt  = turn_cnt - 1'b1;
      end
      ST_TURN_RX: begin
        if (turn_cnt == '0) state_nxt = ST_RX;
        else                turn_nxt  = turn_cnt - 1'b1;
      end
      default: state_nxt = ST_RX;
    endcase
  end

  // Drive enables and data are registered from the next state, so the pins
  // are released on the very edge a TX->RX request is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_RX;
      turn_cnt  <= '0;
      io_t      <= '1;
      io_i      <= '0;
      vcnt      <= '0;
      rx_valid  <= 1'b0;
      rx_change <= 1'b0;
    end else begin
      state     <= state_nxt;
      turn_cnt  <= turn_nxt;
      io_t      <= (state_nxt == ST_TX) ? '0 : '1;
      io_i      <= (state_nxt == ST_TX) ? tx_data : '0;
      rx_change <= rx_valid && (state_nxt == ST_RX) && (|upd);
      if (state_nxt != ST_RX) begin
        vcnt     <= '0;
        rx_valid <= 1'b0;
      end else if (state != ST_RX) begin
        vcnt <= '0;
      end else if (!rx_valid) begin
        if (vcnt == VLAST) rx_valid <= 1'b1;
        else               vcnt     <= vcnt + 1'b1;
      end
    end
  end

  iobuf #(
    .WIDTH(WIDTH)
  ) u_iobuf (
    .i (io_i),
    .t (io_t),
    .o (pad_in),
    .io(io)
  );

  for (genvar b = 0; b < WIDTH; b++) begin : g_filt
    iobuf_ctrl_filt #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_filt (
      .clk   (clk),
      .resetn(resetn),
      .pad   (pad_in[b]),
      .rx    (rx_data[b]),
      .upd   (upd[b])
    );
  end

endmodule

// File: tb/tb_iobuf_ctrl.sv
// Bench for iobuf_ctrl: two instances (dead time 2 and 0) driven by shared stimulus
// and compared every cycle against a behavioural model of the pad controller.
module tb_iobuf_ctrl;
  import iobuf_ctrl_pkg::*;

  localparam int S  = 2;
  localparam int F  = 3;
  localparam int HL = S + F;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req_valid;
  logic       req_out;
  logic [7:0] tx_data;
  logic [7:0] pad_drv;
  logic [1:0] tb_hiz;

  wire  [7:0] io_a;
  wire  [7:0] io_b;
  logic       ready_a, ready_b;
  logic [1:0] st_a, st_b;
  logic [7:0] rx_a, rx_b;
  logic       rv_a, rv_b, rc_a, rc_b;

  // model state, index 0 = TURN_CYCLES 2, index 1 = TURN_CYCLES 0
  logic       m_dir   [2];
  int         m_wait  [2];
  int         m_rxcnt [2];
  logic [7:0] m_rx    [2];
  logic [7:0] m_ioi   [2];
  logic       m_drive [2];
  logic       m_vld   [2];
  logic       m_chg   [2];
  logic [7:0] hist    [2][HL];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign io_a = tb_hiz[0] ? 8'bz : pad_drv;
  assign io_b = tb_hiz[1] ? 8'bz : pad_drv;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_hiz <= 2'b00;
    else         tb_hiz <= {m_drive[1], m_drive[0]};
  end

  iobuf_ctrl #(.WIDTH(8), .TURN_CYCLES(2), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .clk(clk), .resetn(resetn), .dir_req_valid(req_valid), .dir_req_out(req_out),
    .dir_req_ready(ready_a), .dir_state(st_a), .tx_data(tx_data), .rx_data(rx_a),
    .rx_valid(rv_a), .rx_change(rc_a), .io(io_a));

  iobuf_ctrl #(.WIDTH(8), .TURN_CYCLES(0), .SYNC_STAGES(S), .FILTER_LEN(F)) dut_z (
    .clk(clk), .resetn(resetn), .dir_req_valid(req_valid), .dir_req_out(req_out),
    .dir_req_ready(ready_b), .dir_state(st_b), .tx_data(tx_data), .rx_data(rx_b),
    .rx_valid(rv_b), .rx_change(rc_b), .io(io_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int turn_len(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_dir[i] = 1'b0; m_wait[i] = 0; m_rxcnt[i] = 0; m_rx[i] = 8'h00;
      m_ioi[i] = 8'h00; m_drive[i] = 1'b0; m_vld[i] = 1'b0; m_chg[i] = 1'b0;
      for (int k = 0; k < HL; k++) hist[i][k] = 8'h00;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] pad, eq, rxn;
      logic       was_rx, now_rx;
      pad = m_drive[i] ? m_ioi[i] : pad_drv;
      for (int k = HL - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = pad;
      eq = 8'hFF;
      for (int k = 1; k < F; k++) eq &= ~(hist[i][S] ^ hist[i][S+k]);
      rxn = (m_rx[i] & ~eq) | (hist[i][S] & eq);
      was_rx = (m_dir[i] == DIR_RX) && (m_wait[i] == 0);
      if (m_wait[i] > 0) begin
        m_wait[i]--;
      end else if (req_valid && (req_out != m_dir[i])) begin
        m_dir[i]  = req_out;
        m_wait[i] = turn_len(i);
      end
      now_rx = (m_dir[i] == DIR_RX) && (m_wait[i] == 0);
      m_chg[i] = m_vld[i] && now_rx && (rxn != m_rx[i]);
      if (!now_rx || !was_rx) m_rxcnt[i] = 0;
      else if (m_rxcnt[i] < HL) m_rxcnt[i]++;
      m_vld[i]   = (m_rxcnt[i] >= HL);
      m_rx[i]    = rxn;
      m_drive[i] = (m_dir[i] == DIR_TX) && (m_wait[i] == 0);
      m_ioi[i]   = m_drive[i] ? tx_data : 8'h00;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [1:0] st, exp_st;
      logic       rdy, rv, rc;
      logic [7:0] rx, iov, iot;
      if (i == 0) begin
        st = st_a; rdy = ready_a; rv = rv_a; rc = rc_a; rx = rx_a; iov = io_a; iot = dut.io_t;
      end else begin
        st = st_b; rdy = ready_b; rv = rv_b; rc = rc_b; rx = rx_b; iov = io_b; iot = dut_z.io_t;
      end
      if (m_wait[i] > 0) exp_st = m_dir[i] ? ST_TURN_TX : ST_TURN_RX;
      else               exp_st = m_dir[i] ? ST_TX : ST_RX;
      check($sformatf("state%0d", i), st, exp_st);
      check($sformatf("ready%0d", i), rdy, resetn && (m_wait[i] == 0));
      check($sformatf("io_t%0d", i), iot, m_drive[i] ? 8'h00 : 8'hFF);
      check($sformatf("io%0d", i), iov, m_drive[i] ? m_ioi[i] : pad_drv);
      check($sformatf("rx_data%0d", i), rx, m_rx[i]);
      check($sformatf("rx_valid%0d", i), rv, m_vld[i]);
      check($sformatf("rx_change%0d", i), rc, m_chg[i]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset asserted between edges, held across one edge, released between edges.
  task automatic async_reset();
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_io_t", dut.io_t, 8'hFF);
    @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;
    #1;
    check_all();
    check("rst_release_ready", ready_a, 1'b1);
  endtask

  initial begin
    int nchg, ndrv_a, ndrv_b, r;
    resetn = 1'b0; req_valid = 1'b0; req_out = 1'b0; tx_data = 8'h00; pad_drv = 8'h3C;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_all();
    end
    resetn = 1'b1;
    #1;
    check_all();
    repeat (8) tick();

    // RX -> TX with dead time
    req_valid = 1'b1; req_out = DIR_TX; tx_data = 8'hA5;
    tick();
    check("turn_ready_c1", ready_a, 1'b0);
    check("t0_drive_now", io_b, 8'hA5);
    req_valid = 1'b0;
    tick();
    check("turn_ready_c2", ready_a, 1'b0);
    tick();
    check("tx_state", st_a, ST_TX);
    check("tx_first_value", io_a, 8'hA5);
    for (int k = 0; k < 4; k++) begin
      tx_data = 8'($urandom);
      tick();
    end

    // TX -> RX, then wait out the receive settle time
    req_valid = 1'b1; req_out = DIR_RX;
    tick();
    check("release_on_accept", dut.io_t, 8'hFF);
    req_valid = 1'b0;
    tick();
    tick();
    check("back_in_rx", st_a, ST_RX);
    repeat (4) tick();
    check("rx_valid_not_yet", rv_a, 1'b0);
    tick();
    check("rx_valid_set", rv_a, 1'b1);
    check("rx_settled", rx_a, 8'h3C);
    repeat (6) tick();

    // glitch of two cycles on pin 0 is rejected
    nchg = 0;
    pad_drv = 8'h3D;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) pad_drv = 8'h3C;
      tick();
      nchg += int'(rc_a);
    end
    check("glitch_no_pulse", nchg, 0);
    check("glitch_rx0", rx_a[0], 1'b0);
    nchg = 0;
    pad_drv = 8'h3D;
    for (int k = 0; k < 8; k++) begin
      tick();
      nchg += int'(rc_a);
    end
    check("held_one_pulse", nchg, 1);
    check("held_rx", rx_a, 8'h3D);

    // request held through the turnaround
    ndrv_a = 0; ndrv_b = 0;
    req_valid = 1'b1; req_out = DIR_TX; tx_data = 8'h5A;
    for (int k = 0; k < 7; k++) begin
      tick();
      req_out = DIR_RX;
      ndrv_a += int'(dut.io_t == 8'h00);
      ndrv_b += int'(dut_z.io_t == 8'h00);
    end
    check("held_req_drive_a", ndrv_a, 1);
    check("held_req_drive_b", ndrv_b, 1);

    // same-direction requests are no-ops, zero dead time drives at once
    req_out = DIR_RX;
    tick();
    check("noop_rx", st_b, ST_RX);
    req_out = DIR_TX; tx_data = 8'hC3;
    tick();
    check("t0_tx_state", st_b, ST_TX);
    check("t0_io_t", dut_z.io_t, 8'h00);
    tick();
    check("noop_tx", st_b, ST_TX);
    req_valid = 1'b0;
    repeat (2) tick();
    check("a_in_tx", st_a, ST_TX);
    async_reset();
    check("post_rst_state", st_a, ST_RX);
    check("post_rst_valid", rv_a, 1'b0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      req_valid = ($urandom_range(0, 4) == 0);
      req_out   = 1'($urandom);
      tx_data   = 8'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0)      pad_drv = 8'($urandom);
      else if (r == 1) pad_drv = pad_drv ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
